// File: rtl/oscilloscope_pkg.sv
// Shared definitions for the oscilloscope capture path: capture state
// encoding, default capture depth constants used by the capture controller
// and the display reader, and a small sizing helper.
package oscilloscope_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRETRIG  = 3'd1,
        ARMED    = 3'd2,
        POSTTRIG = 3'd3,
        DONE     = 3'd4,
        HOLDOFF  = 3'd5
    } capture_state_t;

    localparam int unsigned DEFAULT_ADDR_BITS    = 10;
    localparam int unsigned DEFAULT_DEPTH        = 1 << DEFAULT_ADDR_BITS;
    localparam int unsigned DEFAULT_PRETRIGGER   = 256;
    localparam int unsigned DEFAULT_HOLDOFF_BITS = 16;
    localparam int unsigned DEFAULT_AUTO_TIMEOUT = 4096;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/capture_counter.sv
// Loadable down-counter shared by the pre-trigger, post-trigger and holdoff
// phases of the capture controller. Load has priority over decrement.
module capture_counter #(
    parameter int unsigned WIDTH = 17
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Counter register: load wins, otherwise step down by one when asked.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (dec) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/trigger_capture_controller.sv
// Oscilloscope acquisition sequencer: fills the pre-trigger window of the
// circular capture RAM, arms the trigger detector, writes the post-trigger
// window, presents the frame to the display and re-arms after holdoff.
// Optional auto trigger on ARMED timeout is built when AUTO_TRIGGER_EN is
// defined; otherwise autoMode is ignored and forcedTrigger is held at 0.
module trigger_capture_controller
    import oscilloscope_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = DEFAULT_ADDR_BITS,
    parameter int unsigned PRETRIGGER   = DEFAULT_PRETRIGGER,
    parameter int unsigned HOLDOFF_BITS = DEFAULT_HOLDOFF_BITS,
    parameter int unsigned AUTO_TIMEOUT = DEFAULT_AUTO_TIMEOUT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sampleEnable,
    input  logic                    isTriggered,
    input  logic                    arm,
    input  logic                    stop,
    input  logic                    singleShot,
    input  logic                    autoMode,
    input  logic                    frameAck,
    input  logic [HOLDOFF_BITS-1:0] holdoffCycles,
    output logic                    triggerDisable,
    output logic                    writeEnable,
    output logic [ADDR_BITS-1:0]    writeAddress,
    output logic [ADDR_BITS-1:0]    triggerAddress,
    output logic                    captureDone,
    output logic                    forcedTrigger,
    output logic                    busy
);

    localparam int unsigned CW       = max_u(ADDR_BITS + 1, HOLDOFF_BITS);
    localparam int unsigned POST_LEN = (1 << ADDR_BITS) - PRETRIGGER;

    localparam logic [CW-1:0] ONE_C      = CW'(1);
    localparam logic [CW-1:0] PRE_LEN_C  = CW'(PRETRIGGER);
    localparam logic [CW-1:0] POST_LEN_C = CW'(POST_LEN);

    capture_state_t   state;
    capture_state_t   nextState;
    logic             ctrLoad;
    logic [CW-1:0]    ctrLoadValue;
    logic             ctrDec;
    logic [CW-1:0]    ctrCount;
    logic             ctrZero;
    logic             trigHit;
    logic             take;
    logic             autoFire;

    capture_counter #(
        .WIDTH(CW)
    ) u_counter (
        .clock     (clock),
        .reset     (reset),
        .load      (ctrLoad),
        .loadValue (ctrLoadValue),
        .dec       (ctrDec),
        .count     (ctrCount),
        .zero      (ctrZero)
    );

`ifdef AUTO_TRIGGER_EN
    localparam int unsigned TW = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(AUTO_TIMEOUT);

    logic [TW-1:0] timeoutCount;

    // ARMED-only sample counter; held at zero elsewhere so it restarts on every entry to ARMED.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeoutCount <= '0;
        end else if (state != ARMED) begin
            timeoutCount <= '0;
        end else if (sampleEnable && (timeoutCount != TIMEOUT_C)) begin
            timeoutCount <= timeoutCount + TW'(1);
        end
    end

    assign autoFire = autoMode && (timeoutCount == TIMEOUT_C);
`else
    logic unused_auto;
    assign unused_auto = autoMode | (AUTO_TIMEOUT == 0);
    assign autoFire    = 1'b0;
    assign forcedTrigger = 1'b0;
`endif

    assign trigHit = isTriggered || autoFire;

    // RAM writes follow the sample strobe while a window is being filled; a stop cycle never writes.
    assign writeEnable = sampleEnable && !stop &&
                         ((state == PRETRIG) || (state == ARMED) || (state == POSTTRIG));

    // Next-state and shared counter control; stop overrides every state.
    always_comb begin
        nextState    = state;
        ctrLoad      = 1'b0;
        ctrLoadValue = '0;
        ctrDec       = 1'b0;
        take         = 1'b0;
        if (stop) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        nextState    = PRETRIG;
                        ctrLoad      = 1'b1;
                        ctrLoadValue = PRE_LEN_C;
                    end
                end
                PRETRIG: begin
                    if (sampleEnable) begin
                        ctrDec = 1'b1;
                        if (ctrCount == ONE_C) begin
                            nextState = ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (trigHit) begin
                        // The write in the trigger cycle is already the first post sample,
                        // so it is taken off the post-trigger length at load time.
                        take         = 1'b1;
                        ctrLoad      = 1'b1;
                        ctrLoadValue = POST_LEN_C - {{(CW-1){1'b0}}, sampleEnable};
                        if (sampleEnable && (POST_LEN_C == ONE_C)) begin
                            nextState = DONE;
                        end else begin
                            nextState = POSTTRIG;
                        end
                    end
                end
                POSTTRIG: begin
                    if (sampleEnable) begin
                        ctrDec = 1'b1;
                        if (ctrCount == ONE_C) begin
                            nextState = DONE;
                        end
                    end
                end
                DONE: begin
                    if (frameAck) begin
                        if (singleShot) begin
                            nextState = IDLE;
                        end else if (holdoffCycles == '0) begin
                            nextState    = PRETRIG;
                            ctrLoad      = 1'b1;
                            ctrLoadValue = PRE_LEN_C;
                        end else begin
                            nextState    = HOLDOFF;
                            ctrLoad      = 1'b1;
                            ctrLoadValue = CW'(holdoffCycles);
                        end
                    end
                end
                HOLDOFF: begin
                    if (ctrZero || (ctrCount == ONE_C)) begin
                        nextState    = PRETRIG;
                        ctrLoad      = 1'b1;
                        ctrLoadValue = PRE_LEN_C;
                    end else begin
                        ctrDec = 1'b1;
                    end
                end
                default: begin
                    nextState = IDLE;
                end
            endcase
        end
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            triggerDisable <= 1'b1;
            captureDone    <= 1'b0;
            triggerAddress <= '0;
`ifdef AUTO_TRIGGER_EN
            forcedTrigger  <= 1'b0;
`endif
        end else begin
            state          <= nextState;
            busy           <= (nextState != IDLE);
            triggerDisable <= (nextState != ARMED);
            captureDone    <= (nextState == DONE);
            if (take) begin
                triggerAddress <= writeAddress - ADDR_BITS'(1);
`ifdef AUTO_TRIGGER_EN
                forcedTrigger  <= !isTriggered;
`endif
            end
        end
    end

    // Circular write pointer; only reset clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            writeAddress <= '0;
        end else if (writeEnable) begin
            writeAddress <= writeAddress + ADDR_BITS'(1);
        end
    end

endmodule

// File: tb/tb_trigger_capture_controller.sv
// Self-checking bench for trigger_capture_controller (ADDR_BITS=4,
// PRETRIGGER=4). Expected write addresses are queued as stimulus is driven
// and popped when the DUT strobes writeEnable. Auto-trigger checks run when
// AUTO_TRIGGER_EN is defined.
module tb_trigger_capture_controller;

    localparam int unsigned AB = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          sampleEnable;
    logic          isTriggered;
    logic          arm;
    logic          stop;
    logic          singleShot;
    logic          autoMode;
    logic          frameAck;
    logic [15:0]   holdoffCycles;
    logic          triggerDisable;
    logic          writeEnable;
    logic [AB-1:0] writeAddress;
    logic [AB-1:0] triggerAddress;
    logic          captureDone;
    logic          forcedTrigger;
    logic          busy;

    int unsigned   vectors = 0;
    int unsigned   miscompares = 0;
    logic [AB-1:0] expq[$];
    logic [AB-1:0] exp_addr = '0;
    logic [AB-1:0] exp_trig;

    trigger_capture_controller #(
        .ADDR_BITS    (AB),
        .PRETRIGGER   (4),
        .HOLDOFF_BITS (16),
        .AUTO_TIMEOUT (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .sampleEnable   (sampleEnable),
        .isTriggered    (isTriggered),
        .arm            (arm),
        .stop           (stop),
        .singleShot     (singleShot),
        .autoMode       (autoMode),
        .frameAck       (frameAck),
        .holdoffCycles  (holdoffCycles),
        .triggerDisable (triggerDisable),
        .writeEnable    (writeEnable),
        .writeAddress   (writeAddress),
        .triggerAddress (triggerAddress),
        .captureDone    (captureDone),
        .forcedTrigger  (forcedTrigger),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Queue the expected write for this cycle (if any), then advance one clock.
    task automatic step(input bit wr);
        if (wr) begin
            expq.push_back(exp_addr);
            exp_addr = exp_addr + AB'(1);
        end
        @(posedge clock);
        #1;
    endtask

    // Write monitor: every DUT write must match the next queued address.
    always @(negedge clock) begin
        if (!reset && writeEnable) begin
            if (expq.size() == 0) begin
                check("wr_unexpected", {28'd0, writeAddress}, 32'hFFFF_FFFF);
            end else begin
                check("wr_addr", {28'd0, writeAddress}, {28'd0, expq.pop_front()});
            end
        end
    end

    initial begin
        reset = 1'b1; sampleEnable = 1'b1; isTriggered = 1'b0; arm = 1'b0; stop = 1'b0;
        singleShot = 1'b1; autoMode = 1'b0; frameAck = 1'b0; holdoffCycles = 16'd3;
        repeat (2) @(posedge clock);
        #1;
        check("rst_we", writeEnable, 0);
        check("rst_wa", writeAddress, 0);
        check("rst_ta", triggerAddress, 0);
        check("rst_done", captureDone, 0);
        check("rst_forced", forcedTrigger, 0);
        check("rst_busy", busy, 0);
        check("rst_tdis", triggerDisable, 1);
        reset = 1'b0;
        step(0);

        // Arm: four pre-trigger writes, then ARMED with the detector enabled.
        arm = 1'b1; step(0); arm = 1'b0;
        check("pre_busy", busy, 1);
        check("pre_tdis", triggerDisable, 1);
        repeat (4) step(1);
        check("armed_tdis", triggerDisable, 0);
        check("armed_wa", writeAddress, 4);
        repeat (21) step(1);               // wraps 15 -> 0 while armed
        check("armed_wa9", writeAddress, 9);

        // Trigger at writeAddress 9: twelve post writes 9..4, then DONE.
        isTriggered = 1'b1; step(1); isTriggered = 1'b0;
        check("trig_addr", triggerAddress, 8);
        check("post_tdis", triggerDisable, 1);
        repeat (10) step(1);
        check("post_not_done", captureDone, 0);
        step(1);
        check("done", captureDone, 1);
        check("done_we", writeEnable, 0);
        arm = 1'b1; step(0); arm = 1'b0;   // arm outside IDLE ignored
        step(0);
        check("done_hold", captureDone, 1);

        // Continuous mode: holdoff of 3 clocks, then a new pre-trigger window.
        singleShot = 1'b0; frameAck = 1'b1; step(0); frameAck = 1'b0;
        check("ack_done_low", captureDone, 0);
        check("holdoff_busy", busy, 1);
        repeat (3) step(0);
        check("repre_wa", writeAddress, 5);
        isTriggered = 1'b1; step(1); isTriggered = 1'b0;  // ignored in PRETRIG
        repeat (3) step(1);
        check("rearmed_tdis", triggerDisable, 0);
        check("ta_kept", triggerAddress, 8);
        repeat (2) step(1);

        // Trigger, then sparse strobes in POSTTRIG.
        exp_trig = exp_addr - AB'(1);
        isTriggered = 1'b1; step(1); isTriggered = 1'b0;
        check("trig_addr2", triggerAddress, exp_trig);
        for (int i = 0; i < 11; i++) begin
            sampleEnable = 1'b0; step(0); step(0);
            sampleEnable = 1'b1;
            if (i == 10) check("sparse_not_done", captureDone, 0);
            step(1);
        end
        check("sparse_done", captureDone, 1);

        // Single shot: frameAck returns to IDLE.
        singleShot = 1'b1; frameAck = 1'b1; step(0); frameAck = 1'b0;
        check("single_done_low", captureDone, 0);
        check("single_busy", busy, 0);

        // stop together with a trigger in ARMED aborts without latching.
        arm = 1'b1; step(0); arm = 1'b0;
        repeat (5) step(1);
        stop = 1'b1; isTriggered = 1'b1; step(0); stop = 1'b0; isTriggered = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_ta", triggerAddress, exp_trig);
        check("stop_tdis", triggerDisable, 1);

`ifdef AUTO_TRIGGER_EN
        // Auto trigger after 8 armed samples, then a real trigger clears the flag.
        singleShot = 1'b0; autoMode = 1'b1;
        arm = 1'b1; step(0); arm = 1'b0;
        repeat (4) step(1);
        repeat (8) step(1);
        check("auto_wait_tdis", triggerDisable, 0);
        exp_trig = exp_addr - AB'(1);
        step(1);
        check("auto_forced", forcedTrigger, 1);
        check("auto_ta", triggerAddress, exp_trig);
        repeat (11) step(1);
        check("auto_done", captureDone, 1);
        frameAck = 1'b1; step(0); frameAck = 1'b0;
        repeat (3) step(0);
        repeat (4) step(1);
        isTriggered = 1'b1; step(1); isTriggered = 1'b0;
        check("real_forced", forcedTrigger, 0);
        stop = 1'b1; step(0); stop = 1'b0;
`endif

        step(0);
        check("wr_queue_left", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
